// File: rtl/regs_dump_ctrl.sv
// Register file dump controller: halts the core, walks every register
// address through a read port and streams the values over valid/ready.
module regs_dump_ctrl #(
  parameter int n     = 8,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          halt_req,
  input  logic          halt_ack,
  output logic [AW-1:0] r_addr,
  input  logic [n-1:0]  reg_data,
  output logic [n-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    LOAD,
    SEND,
    DONE
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          halt_q, halt_d;
  logic          done_q, done_d;

  // Next-state and registered-output logic; abort overrides any active state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    halt_d  = halt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HALT;
          halt_d  = 1'b1;
          addr_d  = '0;
        end
      end
      HALT: begin
        if (halt_ack) state_d = LOAD;
      end
      LOAD: begin
        dout_d  = reg_data;
        valid_d = 1'b1;
        last_d  = (addr_q == LAST);
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dout_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        halt_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      halt_d  = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
    end
  end

  assign r_addr     = addr_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign halt_req   = halt_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule
